br_flow_arb_fixed_aging: RTL and testbench



---
 rtl/br_flow_arb_pkg.sv | 18 +
 rtl/br_flow_arb_age_tracker.sv | 63 ++++++
 rtl/br_flow_arb_fixed_aging.sv | 129 ++++++++++++
 tb/tb_br_flow_arb_fixed_aging.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/br_flow_arb_pkg.sv
// ---------------------------------------------------------------------------
// br_flow_arb_pkg
// Shared sizing helpers for the br_flow_arb family of flow arbiters
// (fixed-priority with aging here; round-robin and LRU aging variants later).
//   flow_id_width(n) : bits needed to encode a flow index for n flows
//   age_width(t)     : bits needed for a saturating age counter reaching t
// ---------------------------------------------------------------------------
package br_flow_arb_pkg;

    function automatic int flow_id_width(input int num_flows);
        return (num_flows > 1) ? $clog2(num_flows) : 1;
    endfunction

    function automatic int age_width(input int age_threshold);
        return $clog2(age_threshold + 1);
    endfunction

endpackage

// File: rtl/br_flow_arb_age_tracker.sv
// ---------------------------------------------------------------------------
// br_flow_arb_age_tracker
// Per-flow saturating age counters. A flow ages while it is requesting and
// losing arbitration in a cycle where the pop stage can advance; it is aged
// once its counter reaches AgeThreshold.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push_valid[N]     per-flow request
//   grant[N]          one-hot arbitration result (before can_advance gating)
//   can_advance       pop stage can take a new entry this cycle
//   aged[N]           flow is requesting and has reached AgeThreshold
// ---------------------------------------------------------------------------
module br_flow_arb_age_tracker
    import br_flow_arb_pkg::*;
#(
    parameter int NumFlows     = 2,
    parameter int AgeThreshold = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NumFlows-1:0] push_valid,
    input  logic [NumFlows-1:0] grant,
    input  logic                can_advance,
    output logic [NumFlows-1:0] aged
);

    localparam int AgeWidth = age_width(AgeThreshold);
    localparam logic [AgeWidth-1:0] AgeMax = AgeWidth'(AgeThreshold);

    logic [AgeWidth-1:0] age_q [NumFlows];
    logic [AgeWidth-1:0] age_d [NumFlows];

    always_comb begin
        for (int i = 0; i < NumFlows; i++) begin
            age_d[i] = age_q[i];
            aged[i]  = (age_q[i] == AgeMax) && push_valid[i];
            if (!push_valid[i]) begin
                // Dropping the request forfeits accumulated age.
                age_d[i] = '0;
            end else if (can_advance) begin
                // Backpressure (can_advance low) freezes the count.
                if (grant[i]) begin
                    age_d[i] = '0;
                end else if (age_q[i] != AgeMax) begin
                    age_d[i] = age_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumFlows; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumFlows; i++) begin
                age_q[i] <= age_d[i];
            end
        end
    end

endmodule

// File: rtl/br_flow_arb_fixed_aging.sv
// ---------------------------------------------------------------------------
// br_flow_arb_fixed_aging
// N:1 flow-controlled arbiter, fixed priority (lowest index wins) with
// per-flow aging that promotes a starved flow above all non-aged flows.
// The winner is captured in a one-entry registered pop stage.
// Build option: define BR_FLOW_ARB_FIXED_AGING_EN to compile in aging;
// otherwise the block is strict fixed priority (AgeThreshold unused).
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   push_valid[N]            per-flow request
//   push_ready[N]            per-flow accept (combinational)
//   push_data[N][Width]      per-flow payload
//   pop_valid / pop_ready    registered output handshake
//   pop_data[Width]          registered payload
//   pop_flow_id              source flow of pop_data
// Handshake: a transfer occurs on a rising edge where valid && ready; valid
// may be raised without waiting for ready, ready is never raised on a flow
// whose valid is low, and a pending pop entry holds until pop_ready.
// ---------------------------------------------------------------------------
module br_flow_arb_fixed_aging
    import br_flow_arb_pkg::*;
#(
    parameter int NumFlows     = 2,
    parameter int Width        = 1,
    parameter int AgeThreshold = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [NumFlows-1:0]                  push_valid,
    output logic [NumFlows-1:0]                  push_ready,
    input  logic [NumFlows-1:0][Width-1:0]       push_data,
    output logic                                 pop_valid,
    input  logic                                 pop_ready,
    output logic [Width-1:0]                     pop_data,
    output logic [flow_id_width(NumFlows)-1:0]   pop_flow_id
);

    localparam int FlowIdWidth = flow_id_width(NumFlows);

    if (NumFlows < 2) begin : g_bad_num_flows
        $error("br_flow_arb_fixed_aging: NumFlows must be >= 2");
    end
    if (Width < 1) begin : g_bad_width
        $error("br_flow_arb_fixed_aging: Width must be >= 1");
    end
    if (AgeThreshold < 1) begin : g_bad_age_threshold
        $error("br_flow_arb_fixed_aging: AgeThreshold must be >= 1");
    end

    logic                   pop_valid_q, pop_valid_d;
    logic [Width-1:0]       pop_data_q, pop_data_d;
    logic [FlowIdWidth-1:0] pop_flow_id_q, pop_flow_id_d;

    logic                   can_advance;
    logic [NumFlows-1:0]    aged;
    logic [NumFlows-1:0]    sel_vec;
    logic [NumFlows-1:0]    grant;
    logic [FlowIdWidth-1:0] win_id;
    logic                   any_valid;

    assign can_advance = !pop_valid_q || pop_ready;

`ifdef BR_FLOW_ARB_FIXED_AGING_EN
    br_flow_arb_age_tracker #(
        .NumFlows     (NumFlows),
        .AgeThreshold (AgeThreshold)
    ) u_age_tracker (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_valid  (push_valid),
        .grant       (grant),
        .can_advance (can_advance),
        .aged        (aged)
    );
`else
    assign aged = '0;
`endif

    // Fixed-priority encode over the aged set if non-empty, else over all
    // requesters. aged is a subset of push_valid, so grant implies valid.
    always_comb begin
        grant   = '0;
        win_id  = '0;
        sel_vec = (|aged) ? aged : push_valid;
        for (int i = NumFlows - 1; i >= 0; i--) begin
            if (sel_vec[i]) begin
                grant  = '0;
                grant[i] = 1'b1;
                win_id = FlowIdWidth'(i);
            end
        end
    end

    assign any_valid = |push_valid;

    // rst_n gating keeps push_ready low while reset is held, so nothing is
    // handed over that the (held-in-reset) pop stage would drop.
    assign push_ready = grant & {NumFlows{can_advance && rst_n}};

    always_comb begin
        pop_valid_d   = pop_valid_q;
        pop_data_d    = pop_data_q;
        pop_flow_id_d = pop_flow_id_q;
        if (can_advance) begin
            pop_valid_d = any_valid;
            if (any_valid) begin
                pop_data_d    = push_data[win_id];
                pop_flow_id_d = win_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_valid_q   <= 1'b0;
            pop_data_q    <= '0;
            pop_flow_id_q <= '0;
        end else begin
            pop_valid_q   <= pop_valid_d;
            pop_data_q    <= pop_data_d;
            pop_flow_id_q <= pop_flow_id_d;
        end
    end

    assign pop_valid   = pop_valid_q;
    assign pop_data    = pop_data_q;
    assign pop_flow_id = pop_flow_id_q;

endmodule

// File: tb/tb_br_flow_arb_fixed_aging.sv
// ---------------------------------------------------------------------------
// tb_br_flow_arb_fixed_aging
// Directed bench for br_flow_arb_fixed_aging (NumFlows=4, Width=8,
// AgeThreshold=3). Expected winners follow the aging sequence when
// BR_FLOW_ARB_FIXED_AGING_EN is defined, strict fixed priority otherwise.
// ---------------------------------------------------------------------------
module tb_br_flow_arb_fixed_aging;

    localparam int NumFlows     = 4;
    localparam int Width        = 8;
    localparam int AgeThreshold = 3;
    localparam int IdW          = 2;
    localparam int W            = IdW + Width;

`ifdef BR_FLOW_ARB_FIXED_AGING_EN
    localparam bit Aging = 1'b1;
`else
    localparam bit Aging = 1'b0;
`endif

    logic                            clk;
    logic                            rst_n;
    logic [NumFlows-1:0]             push_valid;
    logic [NumFlows-1:0]             push_ready;
    logic [NumFlows-1:0][Width-1:0]  push_data;
    logic                            pop_valid;
    logic                            pop_ready;
    logic [Width-1:0]                pop_data;
    logic [IdW-1:0]                  pop_flow_id;

    int errors = 0;
    int checks = 0;
    int seq    = 0;
    logic [W-1:0] exp_q[$];

    br_flow_arb_fixed_aging #(
        .NumFlows     (NumFlows),
        .Width        (Width),
        .AgeThreshold (AgeThreshold)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_valid  (push_valid),
        .push_ready  (push_ready),
        .push_data   (push_data),
        .pop_valid   (pop_valid),
        .pop_ready   (pop_ready),
        .pop_data    (pop_data),
        .pop_flow_id (pop_flow_id)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // One arbitration cycle. Called just after a rising edge. exp_w is the
    // hand-computed winner, or -1 when no grant should be issued.
    task automatic step(input logic [NumFlows-1:0] v, input logic prdy, input int exp_w);
        logic [NumFlows-1:0] exp_ready;
        logic [Width-1:0]    d;
        push_valid = v;
        pop_ready  = prdy;
        for (int i = 0; i < NumFlows; i++) begin
            push_data[i] = Width'((i << 6) | (seq & 63));
        end
        exp_ready = '0;
        if (exp_w >= 0) exp_ready[exp_w] = 1'b1;
        #1;
        check("push_ready", 32'(push_ready), 32'(exp_ready));
        if (exp_w >= 0) begin
            d = Width'((exp_w << 6) | (seq & 63));
            exp_q.push_back({IdW'(exp_w), d});
        end
        seq++;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    // Every cycle the pop stage is valid, its contents must match the head
    // of the expected queue; the head retires on pop_ready.
    always @(negedge clk) begin
        if (rst_n && pop_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got id=%0d data=%0h with empty queue", pop_flow_id, pop_data);
            end else begin
                check("pop_flow_id", 32'(pop_flow_id), 32'(exp_q[0][W-1 -: IdW]));
                check("pop_data", 32'(pop_data), 32'(exp_q[0][Width-1:0]));
                if (pop_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        push_valid = '0;
        pop_ready  = 1'b1;
        push_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        push_valid = '1;
        #1;
        check("reset_pop_valid", 32'(pop_valid), 0);
        check("reset_pop_data", 32'(pop_data), 0);
        check("reset_pop_flow_id", 32'(pop_flow_id), 0);
        check("reset_push_ready", 32'(push_ready), 0);
        rst_n = 1'b1;
        // First edge after release grants flow 0.
        step(4'b1111, 1'b1, 0);
        // Asynchronous reset with an entry in the pop stage.
        check("pre_reset_pop_valid", 32'(pop_valid), 1);
        rst_n = 1'b0;
        #1;
        check("async_reset_pop_valid", 32'(pop_valid), 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(4'b0000, 1'b1, -1);

        // Starvation: flows 0 and 3 always valid.
        for (int r = 0; r < 3; r++) begin
            step(4'b1001, 1'b1, 0);
            step(4'b1001, 1'b1, 0);
            step(4'b1001, 1'b1, 0);
            step(4'b1001, 1'b1, Aging ? 3 : 0);
        end
        step(4'b0000, 1'b1, -1);

        // Backpressure: flow 1 age must freeze while pop_ready is low.
        step(4'b0011, 1'b1, 0);
        for (int k = 0; k < 10; k++) step(4'b0011, 1'b0, -1);
        step(4'b0011, 1'b1, 0);
        step(4'b0011, 1'b1, 0);
        step(4'b0011, 1'b1, Aging ? 1 : 0);
        step(4'b0000, 1'b1, -1);

        // Two aged flows: flows 1 and 2 reach the threshold together.
        step(4'b0111, 1'b1, 0);
        step(4'b0111, 1'b1, 0);
        step(4'b0111, 1'b1, 0);
        step(4'b0111, 1'b1, Aging ? 1 : 0);
        step(4'b0111, 1'b1, Aging ? 2 : 0);
        step(4'b0111, 1'b1, 0);
        step(4'b0000, 1'b1, -1);

        // Valid drop: flow 2 builds age 2, drops for one cycle, restarts.
        step(4'b0101, 1'b1, 0);
        step(4'b0101, 1'b1, 0);
        step(4'b0001, 1'b1, 0);
        step(4'b0101, 1'b1, 0);
        step(4'b0101, 1'b1, 0);
        step(4'b0101, 1'b1, 0);
        step(4'b0101, 1'b1, Aging ? 2 : 0);

        // Lone low-priority flow, then drain.
        step(4'b1000, 1'b1, 3);
        step(4'b0000, 1'b1, -1);
        step(4'b0000, 1'b1, -1);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Watchdog: the directed sequence is bounded, this only guards hangs.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end

endmodule
